// File: rtl/ana_chan_sched_pkg.sv
// Shared types and defaults for the analog channel scheduler:
// FSM state encoding, channel-index width and parameter defaults.
package ana_sched_pkg;

  localparam int N_CH_DEF     = 6;
  localparam int SETTLE_W_DEF = 4;
  localparam int TMO_CYC_DEF  = 255;
  localparam int CHAN_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_SETTLE,
    ST_SAMPLE,
    ST_WAIT,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/ana_chan_sched_if.sv
// Request/converter/switch bundle between the scheduler and its surroundings.
// The slave modport is the scheduler side; master is the environment side.
interface ana_chan_sched_if
  import ana_sched_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF
);

  logic                ena;
  logic [N_CH-1:0]     req;
  logic [SETTLE_W-1:0] settle_cfg;
  logic                conv_done;
  logic [N_CH-1:0]     sw_en;
  logic [CHAN_W-1:0]   chan;
  logic                busy;
  logic                sample;
  logic [N_CH-1:0]     ack;
  logic                err;

  modport master (
    output ena, req, settle_cfg, conv_done,
    input  sw_en, chan, busy, sample, ack, err
  );

  modport slave (
    input  ena, req, settle_cfg, conv_done,
    output sw_en, chan, busy, sample, ack, err
  );

endinterface

// File: rtl/ana_chan_sched_rr_arb.sv
// Combinational round-robin priority search: the first requester found
// after last_grant (wrapping at N_CH) wins; never more than one grant.
module rr_arb
  import ana_sched_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
) (
  input  logic [N_CH-1:0]   req,
  input  logic [CHAN_W-1:0] last_grant,
  output logic [N_CH-1:0]   grant,
  output logic [CHAN_W-1:0] idx
);

  logic              found;
  logic [CHAN_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CHAN_W'((int'(last_grant) + k) % N_CH);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/ana_chan_sched.sv
// Analog channel scheduler: round-robin grant, break-before-make switching,
// programmable settle, sample strobe, converter wait with timeout, ack/err.
module ana_chan_sched
  import ana_sched_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int SETTLE_W = SETTLE_W_DEF,
  parameter int TMO_CYC  = TMO_CYC_DEF
) (
  input logic             clk,
  input logic             rst_n,
  ana_chan_sched_if.slave bus
);

  localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  state_e              state_q, state_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [CHAN_W-1:0]   last_grant_q, last_grant_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                timeout_q, timeout_d;
  logic [N_CH-1:0]     req_q, req_d;
  logic [N_CH-1:0]     rr_grant;
  logic [CHAN_W-1:0]   rr_idx;
  logic [N_CH-1:0]     chan_onehot;
  logic [N_CH-1:0]     ack_w;

  rr_arb #(.N_CH(N_CH)) u_rr_arb (
    .req        (req_q),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .idx        (rr_idx)
  );

  assign chan_onehot = {{(N_CH-1){1'b0}}, 1'b1} << chan_q;
  assign ack_w       = (state_q == ST_RELEASE) ? chan_onehot : '0;

  assign bus.sw_en  = (state_q inside {ST_SETTLE, ST_SAMPLE, ST_WAIT}) ? chan_onehot : '0;
  assign bus.chan   = chan_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.sample = (state_q == ST_SAMPLE);
  assign bus.ack    = ack_w;
  assign bus.err    = (state_q == ST_RELEASE) && timeout_q;

  // Requests pass through one register stage; the channel being acked is
  // masked so a requester dropping req on ack is not granted a second time.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    last_grant_d = last_grant_q;
    settle_d     = settle_q;
    tmo_d        = tmo_q;
    timeout_d    = timeout_q;
    req_d        = bus.req & ~ack_w;
    case (state_q)
      ST_IDLE: begin
        if (bus.ena && (|rr_grant)) begin
          chan_d  = rr_idx;
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        settle_d = bus.settle_cfg;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end
      ST_SAMPLE: begin
        tmo_d     = '0;
        timeout_d = 1'b0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A conversion finishing on the timeout cycle still counts as success.
        if (bus.conv_done) begin
          timeout_d = 1'b0;
          state_d   = ST_RELEASE;
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        last_grant_d = chan_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      last_grant_q <= CHAN_W'(N_CH - 1);
      settle_q     <= '0;
      tmo_q        <= '0;
      timeout_q    <= 1'b0;
      req_q        <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      last_grant_q <= last_grant_d;
      settle_q     <= settle_d;
      tmo_q        <= tmo_d;
      timeout_q    <= timeout_d;
      req_q        <= req_d;
    end
  end

endmodule

// File: tb/tb_ana_chan_sched.sv
// Directed self-checking bench for ana_chan_sched: latency, round-robin order,
// timeout, async reset, ena/req drop handling and stray conv_done pulses.
module tb_ana_chan_sched;

  localparam int TMO = 255;

  logic clk;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   bbm_viol     = 0;
  logic [5:0] prev_sw = '0;

  ana_chan_sched_if #(.N_CH(6), .SETTLE_W(4)) bus ();

  ana_chan_sched #(.N_CH(6), .SETTLE_W(4), .TMO_CYC(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Switches must pass through all-zero between two different channels.
  always @(negedge clk) begin
    if ((prev_sw != 6'd0) && (bus.sw_en != 6'd0) && (prev_sw != bus.sw_en))
      bbm_viol = bbm_viol + 1;
    prev_sw = bus.sw_en;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [5:0] r, input logic [3:0] s);
    bus.ena        = e;
    bus.req        = r;
    bus.settle_cfg = s;
  endtask

  task automatic resetDut();
    rst_n         = 1'b0;
    bus.conv_done = 1'b0;
    applyStimulus(1'b0, 6'd0, 4'd0);
    tick(2);
    checkOutput("rst_busy",   32'(bus.busy),   0);
    checkOutput("rst_sw_en",  32'(bus.sw_en),  0);
    checkOutput("rst_chan",   32'(bus.chan),   0);
    checkOutput("rst_sample", 32'(bus.sample), 0);
    checkOutput("rst_ack",    32'(bus.ack),    0);
    checkOutput("rst_err",    32'(bus.err),    0);
    rst_n = 1'b1;
  endtask

  task automatic waitSample(input string tag);
    int n;
    n = 0;
    while (bus.sample !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checkOutput({tag, "_sample"}, 32'(bus.sample), 1);
  endtask

  // Called with the DUT in SAMPLE: one WAIT cycle, then conv_done.
  task automatic finishOk(input logic [5:0] exp_ack, input string tag);
    tick();
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    checkOutput({tag, "_ack"}, 32'(bus.ack), 32'(exp_ack));
    checkOutput({tag, "_err"}, 32'(bus.err), 0);
    tick();
    checkOutput({tag, "_ack_once"}, 32'(bus.ack), 0);
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0;
    bus.conv_done = 1'b0;
    applyStimulus(1'b0, 6'd0, 4'd0);

    // T1: single request, settle 3, conv_done 5 cycles after sample
    resetDut();
    applyStimulus(1'b1, 6'b000100, 4'd3);
    tick();
    checkOutput("t1_idle_busy", 32'(bus.busy), 0);
    tick();
    checkOutput("t1_break_busy", 32'(bus.busy), 1);
    checkOutput("t1_break_chan", 32'(bus.chan), 2);
    checkOutput("t1_break_sw", 32'(bus.sw_en), 0);
    tick();
    checkOutput("t1_settle_sw", 32'(bus.sw_en), 'h4);
    tick(3);
    checkOutput("t1_settle_end_sample", 32'(bus.sample), 0);
    tick();
    checkOutput("t1_sample_at_7", 32'(bus.sample), 1);
    tick(5);
    checkOutput("t1_wait_ack", 32'(bus.ack), 0);
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    checkOutput("t1_ack", 32'(bus.ack), 'h4);
    checkOutput("t1_err", 32'(bus.err), 0);
    checkOutput("t1_release_sw", 32'(bus.sw_en), 0);
    bus.req = 6'd0;
    tick();
    checkOutput("t1_ack_once", 32'(bus.ack), 0);
    checkOutput("t1_idle_after", 32'(bus.busy), 0);

    // T2: all channels held, grants rotate 0..5 then back to 0
    resetDut();
    applyStimulus(1'b1, 6'b111111, 4'd0);
    for (int i = 0; i < 7; i++) begin
      waitSample($sformatf("t2_%0d", i));
      checkOutput($sformatf("t2_%0d_chan", i), 32'(bus.chan), 32'(i % 6));
      finishOk(6'(1 << (i % 6)), $sformatf("t2_%0d", i));
    end
    checkOutput("t2_break_before_make", 32'(bbm_viol), 0);

    // T3: timeout, ack+err TMO+1 cycles after sample
    resetDut();
    applyStimulus(1'b1, 6'b000001, 4'd0);
    waitSample("t3");
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack == 6'd0 && n < 400);
    checkOutput("t3_tmo_latency", 32'(n), TMO + 1);
    checkOutput("t3_ack", 32'(bus.ack), 'h1);
    checkOutput("t3_err", 32'(bus.err), 1);
    bus.req = 6'd0;
    tick();
    checkOutput("t3_idle", 32'(bus.busy), 0);
    checkOutput("t3_err_once", 32'(bus.err), 0);

    // T4: reset during WAIT opens switches at once, pointer restarts at 0
    applyStimulus(1'b1, 6'b001000, 4'd0);
    waitSample("t4");
    checkOutput("t4_chan", 32'(bus.chan), 3);
    tick();
    checkOutput("t4_wait_sw", 32'(bus.sw_en), 'h8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t4_async_sw", 32'(bus.sw_en), 0);
    checkOutput("t4_async_busy", 32'(bus.busy), 0);
    checkOutput("t4_async_ack", 32'(bus.ack), 0);
    tick();
    checkOutput("t4_held_ack", 32'(bus.ack), 0);
    bus.req = 6'b001001;
    rst_n = 1'b1;
    waitSample("t4_after");
    checkOutput("t4_after_chan", 32'(bus.chan), 0);
    bus.req = 6'd0;
    finishOk(6'b000001, "t4_after");

    // T5: settle 0, req drop after grant, ena low in SETTLE
    applyStimulus(1'b1, 6'b000010, 4'd0);
    tick(2);
    checkOutput("t5_break_chan", 32'(bus.chan), 1);
    checkOutput("t5_break_sw", 32'(bus.sw_en), 0);
    bus.req = 6'b100000;
    tick();
    checkOutput("t5_settle_sw", 32'(bus.sw_en), 'h2);
    checkOutput("t5_settle_sample", 32'(bus.sample), 0);
    bus.ena = 1'b0;
    tick();
    checkOutput("t5_sample", 32'(bus.sample), 1);
    finishOk(6'b000010, "t5");
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus.busy;
    end
    checkOutput("t5_no_grant_ena0", 32'(seen), 0);
    bus.ena = 1'b1;
    waitSample("t5_resume");
    checkOutput("t5_resume_chan", 32'(bus.chan), 5);
    bus.req = 6'd0;
    finishOk(6'b100000, "t5_resume");

    // T6: conv_done in IDLE and SETTLE is ignored
    applyStimulus(1'b1, 6'd0, 4'd3);
    bus.conv_done = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | bus.busy | (|bus.ack);
    end
    bus.conv_done = 1'b0;
    checkOutput("t6_idle_ignore", 32'(seen), 0);
    bus.req = 6'b000100;
    tick(2);
    checkOutput("t6_break_chan", 32'(bus.chan), 2);
    tick();
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    checkOutput("t6_settle_sample", 32'(bus.sample), 0);
    checkOutput("t6_settle_ack", 32'(bus.ack), 0);
    checkOutput("t6_settle_sw", 32'(bus.sw_en), 'h4);
    tick(2);
    checkOutput("t6_still_settle", 32'(bus.sample), 0);
    tick();
    checkOutput("t6_sample_at_7", 32'(bus.sample), 1);
    bus.req = 6'd0;
    finishOk(6'b000100, "t6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
